// File: rtl/sram_test_reporter_pkg.sv
// rtl/sram_test_reporter_pkg.sv - shared constants, FSM states and frame byte helper
package sram_test_reporter_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         FRAME_BYTES   = 9;
  localparam int         STAT_PASS_BIT = 7;
  localparam int         STAT_PAT_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic        test_pass;
    logic [2:0]  pattern;
    logic [15:0] count;
    logic [15:0] read;
    logic [15:0] expected;
  } status_t;

  // Payload bytes 0..7; the checksum byte is accumulated by the sender.
  function automatic logic [7:0] frame_byte(status_t s, logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0: b = SYNC_BYTE;
      3'd1: begin
        b[STAT_PASS_BIT]       = s.test_pass;
        b[STAT_PAT_LSB +: 3]   = s.pattern;
      end
      3'd2: b = s.count[15:8];
      3'd3: b = s.count[7:0];
      3'd4: b = s.read[15:8];
      3'd5: b = s.read[7:0];
      3'd6: b = s.expected[15:8];
      default: b = s.expected[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sram_test_reporter_if.sv
// rtl/sram_test_reporter_if.sv - tester status bundle consumed by the reporter
interface sram_test_reporter_if #(
  parameter int DATA_BITS = 16
);
  logic                 test_done;
  logic                 test_pass;
  logic [2:0]           pattern_state;
  logic [DATA_BITS-1:0] prev_read_data;
  logic [DATA_BITS-1:0] prev_expected_data;

  modport master (
    output test_done, test_pass, pattern_state, prev_read_data, prev_expected_data
  );

  modport slave (
    input test_done, test_pass, pattern_state, prev_read_data, prev_expected_data
  );
endinterface

// File: rtl/sram_test_reporter_uart_tx_byte.sv
// rtl/sram_test_reporter_uart_tx_byte.sv - 8N1 byte transmitter, LSB first, idle high
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] baud_q;
  logic [3:0]        bit_q;
  logic [9:0]        shift_q;
  logic              busy_q;
  logic              done_q;

  // The line is always shift_q[0]; all-ones in the shifter means idle/stop level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start) begin
          shift_q <= {1'b1, data, 1'b0};
          baud_q  <= '0;
          bit_q   <= '0;
          busy_q  <= 1'b1;
        end
      end else if (baud_q == BAUD_LAST) begin
        baud_q  <= '0;
        shift_q <= {1'b1, shift_q[9:1]};
        if (bit_q == 4'd9) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          bit_q <= bit_q + 4'd1;
        end
      end else begin
        baud_q <= baud_q + BAUD_W'(1);
      end
    end
  end

  assign tx   = shift_q[0];
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: rtl/sram_test_reporter.sv
// rtl/sram_test_reporter.sv - counts tester passes and streams 9-byte status frames over UART
module sram_test_reporter
  import sram_test_reporter_pkg::*;
#(
  parameter int DATA_BITS    = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int COUNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_test_reporter_if.slave   st,
  output logic                  uart_tx,
  output logic                  busy,
  output logic [COUNT_BITS-1:0] pass_count,
  output logic                  halted
);
  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);
  localparam logic [3:0] END_IDX  = 4'(FRAME_BYTES);

  state_e                state_q;
  logic                  pass_prev_q, fail_seen_q, pending_q, busy_q, halted_q;
  logic [COUNT_BITS-1:0] count_q, count_d;
  status_t               frame_q, pend_q, snap_d;
  logic [3:0]            idx_q;
  logic [7:0]            csum_q, byte_d;
  logic [DATA_BITS-1:0]  read_w, exp_w;
  logic                  done_ev, fail_ev, trigger;
  logic                  tx_start, tx_busy, tx_done;

  assign read_w  = st.prev_read_data;
  assign exp_w   = st.prev_expected_data;
  assign done_ev = st.test_done && st.test_pass && (state_q != ST_HALT);
  assign fail_ev = pass_prev_q && !st.test_pass && !fail_seen_q && (state_q != ST_HALT);
  assign trigger = done_ev || fail_ev;
  assign count_d = done_ev ? count_q + COUNT_BITS'(1) : count_q;

  // Snapshot reflects this edge's inputs, including the pass being counted now.
  always_comb begin
    snap_d           = '0;
    snap_d.test_pass = st.test_pass;
    snap_d.pattern   = st.pattern_state;
    snap_d.count     = 16'(count_d);
    snap_d.read      = 16'(read_w);
    snap_d.expected  = 16'(exp_w);
  end

  assign byte_d   = (idx_q == LAST_IDX) ? csum_q : frame_byte(frame_q, idx_q[2:0]);
  assign tx_start = (state_q == ST_LOAD) && !tx_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pass_prev_q <= 1'b0;
      fail_seen_q <= 1'b0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      count_q     <= '0;
      frame_q     <= '0;
      pend_q      <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
    end else begin
      pass_prev_q <= st.test_pass;
      count_q     <= count_d;
      if (fail_ev) fail_seen_q <= 1'b1;
      // A failure always claims the single pending slot; a pass only takes it when empty.
      if ((state_q == ST_LOAD || state_q == ST_SEND) && trigger && (!pending_q || fail_ev)) begin
        pending_q <= 1'b1;
        pend_q    <= snap_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (pending_q || trigger) begin
            frame_q   <= pending_q ? pend_q : snap_d;
            pending_q <= pending_q && fail_ev;
            if (pending_q && fail_ev) pend_q <= snap_d;
            idx_q     <= '0;
            csum_q    <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!tx_busy) begin
            csum_q  <= csum_q ^ byte_d;
            idx_q   <= idx_q + 4'd1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_done) begin
            if (idx_q < END_IDX) begin
              state_q <= ST_LOAD;
            end else begin
              busy_q <= 1'b0;
              if (!frame_q.test_pass) begin
                halted_q <= 1'b1;
                state_q  <= ST_HALT;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .data  (byte_d),
    .tx    (uart_tx),
    .busy  (tx_busy),
    .done  (tx_done)
  );

  assign busy       = busy_q;
  assign halted     = halted_q;
  assign pass_count = count_q;
endmodule

// File: tb/tb_sram_test_reporter.sv
// tb/tb_sram_test_reporter.sv - randomized and directed bench with a frame-level reference model
module tb_sram_test_reporter;
  localparam int DATA_BITS  = 16;
  localparam int CPB        = 4;
  localparam int COUNT_BITS = 4;
  localparam int P          = 10 * CPB + 2;
  localparam int FRAME_CYC  = 9 * P;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  uart_tx, busy, halted;
  logic [COUNT_BITS-1:0] pass_count;

  sram_test_reporter_if #(.DATA_BITS(DATA_BITS)) st_if ();

  sram_test_reporter #(
    .DATA_BITS(DATA_BITS), .CLKS_PER_BIT(CPB), .COUNT_BITS(COUNT_BITS)
  ) dut (
    .clk(clk), .reset(reset), .st(st_if),
    .uart_tx(uart_tx), .busy(busy), .pass_count(pass_count), .halted(halted)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames as byte arrays, timeline as plain cycle arithmetic.
  int          cyc = 0, m_count = 0, cur_start = 0, cur_end = 0;
  bit          m_busy = 0, m_halt = 0, m_active = 0, m_pend = 0, m_prev = 0, m_fail_seen = 0, m_tx = 1;
  logic [71:0] cur_frame = '0, pend_frame = '0;
  logic [71:0] log_frames[$];
  int          log_starts[$];

  function automatic logic [71:0] mk_frame(logic p, logic [2:0] pat, logic [15:0] cnt,
                                           logic [15:0] rd, logic [15:0] ex);
    logic [7:0]  b[9];
    logic [71:0] f;
    b[0] = 8'hA5; b[1] = {p, 4'b0, pat};
    b[2] = cnt[15:8]; b[3] = cnt[7:0];
    b[4] = rd[15:8];  b[5] = rd[7:0];
    b[6] = ex[15:8];  b[7] = ex[7:0];
    b[8] = 8'h00;
    for (int i = 0; i < 8; i++) b[8] = b[8] ^ b[i];
    for (int i = 0; i < 9; i++) f[71 - 8*i -: 8] = b[i];
    return f;
  endfunction

  function automatic logic [71:0] frame_at(int i);
    if (i < log_frames.size()) return log_frames[i];
    return '0;
  endfunction

  function automatic int start_at(int i);
    if (i < log_starts.size()) return log_starts[i];
    return -1;
  endfunction

  task automatic start_frame(input logic [71:0] f);
    m_active  = 1; m_busy = 1;
    cur_frame = f; cur_start = cyc; cur_end = cyc + FRAME_CYC;
    log_frames.push_back(f);
    log_starts.push_back(cyc);
  endtask

  always @(posedge clk or posedge reset) begin
    bit          de, fe;
    logic [71:0] snap;
    logic [9:0]  fb;
    int          o;
    if (reset) begin
      cyc = 0; m_count = 0; m_busy = 0; m_halt = 0; m_active = 0; m_pend = 0;
      m_prev = 0; m_fail_seen = 0; m_tx = 1;
      log_frames.delete(); log_starts.delete();
    end else begin
      cyc++;
      de = st_if.test_done && st_if.test_pass && !m_halt;
      fe = m_prev && !st_if.test_pass && !m_fail_seen && !m_halt;
      m_prev = st_if.test_pass;
      if (fe) m_fail_seen = 1;
      if (de) m_count = (m_count + 1) % (1 << COUNT_BITS);
      snap = mk_frame(st_if.test_pass, st_if.pattern_state, 16'(m_count),
                      st_if.prev_read_data, st_if.prev_expected_data);
      if (!m_halt) begin
        if (!m_active) begin
          if (m_pend) begin
            start_frame(pend_frame);
            if (fe) pend_frame = snap; else m_pend = 0;
          end else if (de || fe) begin
            start_frame(snap);
          end
        end else if ((de || fe) && (!m_pend || fe)) begin
          m_pend = 1; pend_frame = snap;
        end
        if (m_active && cyc == cur_end) begin
          m_active = 0; m_busy = 0;
          if (!cur_frame[63]) m_halt = 1;
        end
      end
      m_tx = 1;
      if (m_active) begin
        o = cyc - cur_start - 1;
        if (o >= 0 && (o % P) < 10 * CPB) begin
          fb   = {1'b1, cur_frame[71 - 8*(o / P) -: 8], 1'b0};
          m_tx = fb[(o % P) / CPB];
        end
      end
    end
  end

  always @(negedge clk) begin
    check("uart_tx", uart_tx, m_tx);
    check("busy", busy, m_busy);
    check("pass_count", pass_count, m_count[COUNT_BITS-1:0]);
    check("halted", halted, m_halt);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_done();
    st_if.test_done = 1'b1; tick(); st_if.test_done = 1'b0;
  endtask

  task automatic set_status(input logic [2:0] pat, input logic [15:0] rd, input logic [15:0] ex);
    st_if.pattern_state = pat; st_if.prev_read_data = rd; st_if.prev_expected_data = ex;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    st_if.test_done = 1'b0; st_if.test_pass = 1'b1;
    set_status(3'd0, 16'h0000, 16'h0000);
    tick(2); reset = 1'b0; tick(2);
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((m_active || m_pend) && n < 5000) begin tick(); n++; end
    check({name, " settle timeout"}, n >= 5000, 0);
  endtask

  initial begin
    int n, fail_at, prob;
    st_if.test_done = 1'b0; st_if.test_pass = 1'b1;
    set_status(3'd0, 16'h0000, 16'h0000);

    do_reset();
    tick(1000);
    check("idle pass_count", pass_count, 0);
    check("idle tx", uart_tx, 1);
    check("idle busy", busy, 0);
    check("idle no frames", log_frames.size(), 0);

    do_reset();
    set_status(3'd2, 16'h55AA, 16'h55AA);
    pulse_done();
    n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    check("busy length", n, 378);
    check("single frame", frame_at(0), 72'hA5_82_00_01_55_AA_55_AA_26);
    check("single pass_count", pass_count, 1);

    do_reset();
    pulse_done(); tick(9); pulse_done(); tick(9); pulse_done();
    wait_quiet("triple");
    check("triple frames", log_frames.size(), 2);
    check("triple count0", frame_at(0)[55:40], 16'd1);
    check("triple count1", frame_at(1)[55:40], 16'd2);
    check("triple pass_count", pass_count, 3);

    do_reset();
    repeat (5) begin pulse_done(); wait_quiet("pass"); end
    set_status(3'd1, 16'h1234, 16'h1235);
    st_if.test_pass = 1'b0;
    tick();
    wait_quiet("fail idle");
    check("fail frame", frame_at(5), 72'hA5_01_00_05_12_34_12_35_A0);
    check("fail halted", halted, 1);
    pulse_done(); tick(50);
    check("halt no frame", log_frames.size(), 6);
    check("halt busy", busy, 0);

    do_reset();
    pulse_done(); tick(100);
    st_if.test_pass = 1'b0;
    wait_quiet("fail busy");
    check("midfail frames", log_frames.size(), 2);
    check("midfail pass bit", frame_at(1)[63], 0);
    check("midfail back to back", start_at(1), start_at(0) + FRAME_CYC + 1);
    check("midfail halted", halted, 1);

    do_reset();
    pulse_done(); tick(1 + 4 * P + 5);
    #1 reset = 1'b1;
    #1;
    check("abort tx", uart_tx, 1);
    check("abort busy", busy, 0);
    check("abort pass_count", pass_count, 0);
    tick(2); reset = 1'b0; tick(2);
    set_status(3'd5, 16'hBEEF, 16'hBEEF);
    pulse_done();
    wait_quiet("after abort");
    check("after abort frames", log_frames.size(), 1);
    check("after abort frame", frame_at(0), 72'hA5_85_00_01_BE_EF_BE_EF_21);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      fail_at = (r == 0) ? 100000 : $urandom_range(800, 2800);
      prob    = (r == 1) ? 3 : 30;
      for (int c = 0; c < 3000; c++) begin
        st_if.test_done = ($urandom_range(0, prob - 1) == 0);
        set_status(3'($urandom), 16'($urandom), 16'($urandom));
        if (c == fail_at) st_if.test_pass = 1'b0;
        tick();
      end
      st_if.test_done = 1'b0;
      wait_quiet("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
